tx_symbol_scheduler: RTL and testbench
======================================

# tx_symbol_scheduler

Sequencer between the UART receive path and the BPSK modulator. It buffers received bytes in a small FIFO, presents each byte to the combinational Hamming encoder, and serialises the 12-bit codeword MSB-first into timed symbols. It owns the carrier phase counter that addresses the sine LUT and tells the modulator which polarity to emit. It replaces free-running modulation with framed, gap-free symbol scheduling.

## Interface
- DATA_W, 8, byte width from the UART receiver
- CODE_W, 12, codeword width from the encoder
- SPS, 256, clock cycles per symbol; equals the sine LUT length
- PH_W, 8, carrier phase width, clog2(SPS)
- FIFO_DEPTH, 4, byte FIFO entries (power of two)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  enable; low acts as a synchronous abort/flush
- byte_in  in  DATA_W  received byte
- byte_valid  in  1  one-cycle strobe; byte_in is valid
- enc_data  out  DATA_W  byte presented to the encoder (head of FIFO)
- enc_code  in  CODE_W  encoder result for enc_data, combinational
- carrier_phase  out  PH_W  sine LUT address
- mod_bit  out  1  current symbol; 0 selects sin, 1 selects neg_sin
- mod_en  out  1  modulator output active; when low, the modulator outputs 0
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on the last cycle of a frame
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
- overflow  out  1  sticky; set when a write is dropped

## Operation
- States:
  - IDLE: waits for the FIFO to be non-empty.
  - LOAD: lasts one cycle. Pops the FIFO and latches enc_code into the shift register.
  - PRE: present only when the preamble is compiled in. Sends 4 symbols.
  - DATA: sends CODE_W symbols.
- Transitions:
  - IDLE → LOAD when the FIFO is not empty and en=1.
  - LOAD → PRE, or → DATA when the preamble is not compiled in.
  - PRE → DATA after 4 symbols.
  - On the last cycle of the last DATA symbol: go to LOAD if the FIFO is not empty, otherwise go to IDLE.
- carrier_phase:
  - Counts 0..SPS-1 within each symbol and is 0 on the first cycle of every symbol.
  - Held at 0 in IDLE and LOAD.
- mod_bit is the MSB of the shift register. The register shifts left at the end of each symbol.
- mod_en and busy are high in PRE and DATA. busy is also high in LOAD.
- FIFO behaviour:
  - A write when full is dropped and sets overflow, unless a pop occurs in the same cycle. In that case the write is accepted.
  - A write into an empty FIFO makes it non-empty on the next cycle. There is no bypass.
- en=0 has effect on the next edge: state goes to IDLE, the FIFO is flushed, overflow is cleared, writes are ignored, and the phase counter is zeroed. No frame_done pulse is issued.
- Reset values: carrier_phase=0, mod_bit=0, mod_en=0, busy=0, frame_done=0, fifo_full=0, overflow=0, enc_data=0, state=IDLE.

## Timing
- Latency:
  - byte_valid is sampled at edge E0.
  - LOAD is entered at E1.
  - At E2 the code is latched, and mod_en rises on the cycle following E2.
- Frame length is (4+CODE_W)×SPS cycles with the preamble and CODE_W×SPS cycles without it.
- Back-to-back frames have exactly one LOAD cycle between them. During that cycle mod_en=0.
- frame_done is asserted together with the last symbol cycle (carrier_phase=SPS-1).
- Reset assertion mid-frame clears all outputs immediately, because reset is asynchronous.

## Configuration
- Macro: TX_PREAMBLE_EN.
- Defined: every frame is prefixed by the symbols 1,0,1,0 in the PRE state, for 16 symbols per frame.
- Undefined: the PRE state and its logic are absent. LOAD goes directly to DATA, giving 12 symbols per frame.

## Structure
- Shared package transceiver_pkg holds:
  - the state encoding (IDLE, LOAD, PRE, DATA);
  - the preamble pattern 4'b1010 and its length 4;
  - the DATA_W/CODE_W defaults.
- Sub-module tx_byte_fifo: a synchronous FIFO with full/empty outputs. It has no output register; its head feeds enc_data directly.

## Test plan
All tests use SPS=4 and a bench encoder stub enc_code={4'b1001, enc_data}.
- Reset: drive rst low mid-frame → all outputs are 0 immediately; after release the block stays IDLE with carrier_phase=0.
- Single byte 0xA5, no macro:
  - mod_en rises 2 cycles after the write edge.
  - mod_bit sequence is 1,0,0,1,1,0,1,0,0,1,0,1, each held 4 cycles, with carrier_phase 0..3 repeating.
  - frame_done pulses once after 48 cycles.
- Same byte with TX_PREAMBLE_EN: mod_bit sequence is 1,0,1,0 followed by the 12 code bits; frame_done pulses after 64 cycles.
- Two bytes 0x00 and 0xFF written 1 cycle apart:
  - frames run back-to-back;
  - exactly one cycle with mod_en=0 separates them;
  - the second codeword is 12'h9FF.
- FIFO boundaries:
  - Write 6 bytes on consecutive cycles while idle → fifo_full asserts; one byte is accepted via the simultaneous pop; overflow=1; 5 frames are sent.
  - A write on a full FIFO with no pop → dropped, with overflow set.
- Abort: deassert en during DATA symbol 5 → next cycle mod_en=0, busy=0, overflow=0, and the FIFO is empty; no frame_done pulse is issued.

Source files
------------

// File: rtl/transceiver_pkg.sv
// Shared definitions for the transmit path: sequencer state encoding,
// preamble pattern and default datapath widths.
package transceiver_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CODE_W_DEF = 12;

  // Frame preamble, sent MSB-first ahead of the codeword when compiled in.
  localparam int                  PRE_LEN     = 4;
  localparam logic [PRE_LEN-1:0]  PRE_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PRE  = 2'd2,
    S_DATA = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Small synchronous byte FIFO with a combinational head (no output register),
// sticky overflow flag and a synchronous flush that also discards writes.
module tx_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW:0]       rd_ptr_reg, rd_ptr_next;
  logic              overflow_reg, overflow_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign pop  = rd_en && !empty && !flush;
  assign push = wr_en && !flush && (!full || pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign overflow = overflow_reg;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      overflow_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (wr_en && full && !pop) overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Frames buffered bytes into gap-free BPSK symbols: FIFO -> encoder -> MSB-first
// shift register, and drives the carrier phase. TX_PREAMBLE_EN adds a 1010 preamble.
module tx_symbol_scheduler
  import transceiver_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CODE_W     = CODE_W_DEF,
  parameter int SPS        = 256,
  parameter int PH_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic [DATA_W-1:0] enc_data,
  input  logic [CODE_W-1:0] enc_code,
  output logic [PH_W-1:0]   carrier_phase,
  output logic              mod_bit,
  output logic              mod_en,
  output logic              busy,
  output logic              frame_done,
  output logic              fifo_full,
  output logic              overflow
);

`ifdef TX_PREAMBLE_EN
  localparam int SR_W = CODE_W + PRE_LEN;
`else
  localparam int SR_W = CODE_W;
`endif
  localparam int SC_W = $clog2(SR_W);

  tx_state_e         state_reg, state_next;
  logic [PH_W-1:0]   phase_reg, phase_next;
  logic [SC_W-1:0]   sym_cnt_reg, sym_cnt_next;
  logic [SR_W-1:0]   shift_reg, shift_next;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              frame_last;
  logic              sym_end;

  tx_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (!en),
    .wr_en    (byte_valid && en),
    .wr_data  (byte_in),
    .rd_en    (fifo_pop),
    .rd_data  (enc_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign sym_end = (phase_reg == PH_W'(SPS - 1));

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    sym_cnt_next = sym_cnt_reg;
    shift_next   = shift_reg;
    fifo_pop     = 1'b0;
    frame_last   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        phase_next   = '0;
        sym_cnt_next = '0;
        if (!fifo_empty) state_next = S_LOAD;
      end

      S_LOAD: begin
        fifo_pop     = 1'b1;
        phase_next   = '0;
        sym_cnt_next = '0;
`ifdef TX_PREAMBLE_EN
        shift_next   = {PRE_PATTERN, enc_code};
        state_next   = S_PRE;
`else
        shift_next   = enc_code;
        state_next   = S_DATA;
`endif
      end

`ifdef TX_PREAMBLE_EN
      S_PRE: begin
        if (sym_end) begin
          phase_next = '0;
          shift_next = {shift_reg[SR_W-2:0], 1'b0};
          if (sym_cnt_reg == SC_W'(PRE_LEN - 1)) begin
            sym_cnt_next = '0;
            state_next   = S_DATA;
          end else begin
            sym_cnt_next = sym_cnt_reg + 1'b1;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
`endif

      S_DATA: begin
        if (sym_end) begin
          phase_next = '0;
          shift_next = {shift_reg[SR_W-2:0], 1'b0};
          if (sym_cnt_reg == SC_W'(CODE_W - 1)) begin
            // Chain straight into the next frame with a single LOAD cycle.
            frame_last   = 1'b1;
            sym_cnt_next = '0;
            state_next   = fifo_empty ? S_IDLE : S_LOAD;
          end else begin
            sym_cnt_next = sym_cnt_reg + 1'b1;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Dropping en aborts the frame outright on the next edge.
    if (!en) begin
      state_next   = S_IDLE;
      phase_next   = '0;
      sym_cnt_next = '0;
      shift_next   = '0;
      fifo_pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      phase_reg   <= '0;
      sym_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      sym_cnt_reg <= sym_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  assign carrier_phase = phase_reg;
  assign mod_bit       = shift_reg[SR_W-1];
  assign mod_en        = (state_reg == S_PRE) || (state_reg == S_DATA);
  assign busy          = mod_en || (state_reg == S_LOAD);
  assign frame_done    = frame_last && en;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Bench for tx_symbol_scheduler at SPS=4 with an encoder stub {4'b1001, data};
// honours TX_PREAMBLE_EN for the expected symbol stream.
module tb_tx_symbol_scheduler;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int SPS    = 4;
  localparam int PH_W   = 2;
  localparam int DEPTH  = 4;
`ifdef TX_PREAMBLE_EN
  localparam int          NSYM     = 16;
  localparam logic [15:0] PRE_BITS = 16'hA000;
`else
  localparam int          NSYM     = 12;
  localparam logic [15:0] PRE_BITS = 16'h0000;
`endif
  localparam int FLEN = NSYM * SPS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b1;
  logic [DATA_W-1:0] byte_in = '0;
  logic              byte_valid = 1'b0;
  logic [DATA_W-1:0] enc_data;
  logic [CODE_W-1:0] enc_code;
  logic [PH_W-1:0]   carrier_phase;
  logic              mod_bit, mod_en, busy, frame_done, fifo_full, overflow;
  logic [31:0]       outs;

  tx_symbol_scheduler #(
    .DATA_W(DATA_W), .CODE_W(CODE_W), .SPS(SPS), .PH_W(PH_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .byte_in(byte_in), .byte_valid(byte_valid),
    .enc_data(enc_data), .enc_code(enc_code), .carrier_phase(carrier_phase),
    .mod_bit(mod_bit), .mod_en(mod_en), .busy(busy), .frame_done(frame_done),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  assign enc_code = {4'b1001, enc_data};
  assign outs = {16'b0, enc_data, carrier_phase, mod_bit, mod_en, busy,
                 frame_done, fifo_full, overflow};

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] code;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    cyc();
    byte_valid = 1'b0;
  endtask

  task automatic wait_mod_en(output int n);
    n = 0;
    while (!mod_en && n < 20) begin
      cyc();
      n++;
    end
  endtask

  // Collects one symbol bit per symbol while checking phase ramp and hold.
  task automatic capture_frame(output logic [15:0] bits, output int dc, output int dp,
                               output int bad);
    bits = '0; dc = 0; dp = -1; bad = 0;
    for (int i = 0; i < FLEN; i++) begin
      if (!mod_en || !busy || carrier_phase != PH_W'(i % SPS)) bad++;
      if (i % SPS == 0) bits = {bits[14:0], mod_bit};
      else if (mod_bit != bits[0]) bad++;
      if (frame_done) begin
        dc++;
        dp = i;
      end
      cyc();
    end
  endtask

  task automatic count_frames(input int budget, output int frames);
    frames = 0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) frames++;
      cyc();
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  q[$];
    logic [15:0] fbits;
    logic [31:0] exp;
    int dc, dp, bad, n, g, fr, seen;
    bit act, movf, pop;
    int k;

    tbl[0] = '{8'hA5, 12'h9A5};
    tbl[1] = '{8'h00, 12'h900};
    tbl[2] = '{8'hFF, 12'h9FF};
    tbl[3] = '{8'h3C, 12'h93C};

    // Reset state, then asynchronous reset in the middle of a frame.
    repeat (2) cyc();
    check("reset_outputs", outs, 32'h0);
    rst = 1'b1;
    cyc();
    write_byte(8'hC3);
    wait_mod_en(n);
    repeat (10) cyc();
    check("midframe_active", {31'b0, mod_en}, 32'h1);
    rst = 1'b0;
    #1;
    check("async_reset_clear", outs, 32'h0);
    cyc();
    rst = 1'b1;
    repeat (5) cyc();
    check("post_reset_idle", {29'b0, busy, carrier_phase}, 32'h0);
    $display("reset sequence done");

    // Table-driven single-byte frames.
    for (int v = 0; v < 4; v++) begin
      write_byte(tbl[v].b);
      wait_mod_en(n);
      check("latency", n, 2);
      capture_frame(bits, dc, dp, bad);
      check("code_bits", bits, PRE_BITS | 16'(tbl[v].code));
      check("frame_done_cnt", dc, 1);
      check("frame_done_pos", dp, FLEN - 1);
      check("symbol_timing", bad, 0);
      check("idle_after", {30'b0, mod_en, busy}, 32'h0);
      $display("vector %0d byte %02h symbols %04h", v, tbl[v].b, bits);
      repeat (3) cyc();
    end

    // Back-to-back frames from two consecutive writes.
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_mod_en(n);
    check("b2b_latency", n, 1);
    capture_frame(bits, dc, dp, bad);
    check("b2b_first_code", bits, PRE_BITS | 16'h0900);
    check("b2b_first_done", dc, 1);
    check("b2b_load_cycle", {30'b0, busy, mod_en}, 32'h2);
    g = 0;
    while (!mod_en && g < 20) begin
      cyc();
      g++;
    end
    check("b2b_gap", g, 1);
    capture_frame(bits, dc, dp, bad);
    check("b2b_second_code", bits, PRE_BITS | 16'h09FF);
    check("b2b_second_timing", bad, 0);
    $display("back-to-back sequence done");
    repeat (3) cyc();

    // Six writes while idle: fifo fills, last write dropped, five frames.
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      write_byte(8'h11 + 8'(i));
      if (fifo_full) seen = 1;
    end
    check("fill_full_seen", seen, 1);
    check("fill_overflow", {31'b0, overflow}, 32'h1);
    count_frames(5 * (FLEN + 1) + 20, fr);
    check("fill_frames", fr, 5);
    check("fill_overflow_sticky", {30'b0, busy, overflow}, 32'h1);
    $display("fifo fill sequence done");

    // Abort during DATA symbol 5: everything flushes, no frame_done.
    write_byte(8'h5A);
    write_byte(8'h33);
    wait_mod_en(n);
    repeat ((NSYM - 12 + 4) * SPS + 1) cyc();
    en = 1'b0;
    #1;
    check("abort_no_done", {31'b0, frame_done}, 32'h0);
    cyc();
    check("abort_state", {26'b0, mod_en, busy, overflow, fifo_full, carrier_phase}, 32'h0);
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < FLEN + 10; i++) begin
      if (busy || frame_done) seen = 1;
      cyc();
    end
    check("abort_flushed", seen, 0);

    // Abort on the very last symbol cycle suppresses frame_done.
    write_byte(8'h77);
    wait_mod_en(n);
    repeat (FLEN - 1) cyc();
    check("last_cycle_phase", {30'b0, carrier_phase}, SPS - 1);
    en = 1'b0;
    #1;
    check("abort_last_done", {31'b0, frame_done}, 32'h0);
    cyc();
    en = 1'b1;
    $display("abort sequences done");

    // Write into a full fifo during the LOAD pop is accepted.
    write_byte(8'hA0);
    wait_mod_en(n);
    for (int i = 1; i <= 4; i++) write_byte(8'hA0 + 8'(i));
    check("fwp_full", {31'b0, fifo_full}, 32'h1);
    n = 0;
    while (!frame_done && n < FLEN + 5) begin
      cyc();
      n++;
    end
    check("fwp_done_seen", {31'b0, frame_done}, 32'h1);
    cyc();
    check("fwp_load_cycle", {30'b0, busy, mod_en}, 32'h2);
    write_byte(8'hA5);
    check("fwp_accepted", {30'b0, fifo_full, overflow}, 32'h2);
    count_frames(5 * (FLEN + 1) + 10, fr);
    check("fwp_frames", fr, 5);
    $display("full-with-pop sequence done");

    // Randomised traffic against a frame-offset reference model.
    en = 1'b0;
    cyc();
    en = 1'b1;
    q.delete();
    act = 0; k = 0; movf = 0; fbits = '0;
    for (int c = 0; c < 4000; c++) begin
      en         = ($urandom_range(0, 99) != 0);
      byte_valid = ($urandom_range(0, 15) == 0);
      byte_in    = 8'($urandom);
      #1;
      exp = '0;
      exp[15:8] = (q.size() > 0) ? q[0] : 8'h00;
      if (act && k > 0) begin
        exp[7:6] = PH_W'((k - 1) % SPS);
        exp[5]   = fbits[NSYM - 1 - (k - 1) / SPS];
        exp[4]   = 1'b1;
      end
      exp[3] = act;
      exp[2] = act && (k == FLEN) && en;
      exp[1] = (q.size() == DEPTH);
      exp[0] = movf;
      check("random_cycle", outs, exp);

      if (!en) begin
        q.delete();
        movf = 0; act = 0; k = 0;
      end else begin
        pop = 0;
        if (act && k == 0) begin
          fbits = 16'({4'b1001, q[0]}) | PRE_BITS;
          pop = 1;
        end
        if (act) begin
          if (k == FLEN) begin
            act = (q.size() > 0);
            k = 0;
          end else begin
            k++;
          end
        end else if (q.size() > 0) begin
          act = 1;
          k = 0;
        end
        if (pop) void'(q.pop_front());
        if (byte_valid) begin
          if (q.size() < DEPTH) q.push_back(byte_in);
          else movf = 1;
        end
      end
      cyc();
    end
    byte_valid = 1'b0;
    $display("random sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
